// File: rtl/register_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : register_file_mp                                           |
// | Description : Multi-port register file with NUM_READ combinational read  |
// |               ports, two prioritised write ports (load beats ALU),       |
// |               optional write-to-read bypass and a per-register busy      |
// |               scoreboard with alloc / flush.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic [1:0]                     we,
  input  logic [2*ADDR_WIDTH-1:0]        wr_addr,
  input  logic [2*DATA_WIDTH-1:0]        wr_data,
  input  logic                           alloc_en,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr,
  input  logic                           flush
);

  // One extra bit so the compare also works when NUM_REGS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] c_num_regs = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] w_wr_addr [2];
  logic [DATA_WIDTH-1:0] w_wr_data [2];
  logic [1:0]            w_wr_ok;

  logic [DATA_WIDTH-1:0] w_mem [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy;

  // Unpack write ports; a write is effective only for an in-range,
  // non-hardwired address. The same qualifier gates the bypass path.
  for (genvar k = 0; k < 2; k++) begin : g_wr
    assign w_wr_addr[k] = wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wr_data[k] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_wr_ok[k]   = we[k]
                        && ({1'b0, w_wr_addr[k]} < c_num_regs)
                        && !(ZERO_REG && (w_wr_addr[k] == '0));
  end

  // Per-register storage; address decode is local so out-of-range
  // writes and allocs simply match no register.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (ZERO_REG && (r == 0)) begin : g_zero
      assign w_mem[r]  = '0;
      assign w_busy[r] = 1'b0;
    end else begin : g_live
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_busy;
      logic [1:0]            w_hit;
      logic                  w_alloc;

      assign w_hit[0] = w_wr_ok[0] && (w_wr_addr[0] == ADDR_WIDTH'(r));
      assign w_hit[1] = w_wr_ok[1] && (w_wr_addr[1] == ADDR_WIDTH'(r));
      assign w_alloc  = alloc_en && (alloc_addr == ADDR_WIDTH'(r));

      // Data: load port wins on collision. Busy: flush > alloc > write-clear.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (w_hit[1]) begin
            r_data <= w_wr_data[1];
          end else if (w_hit[0]) begin
            r_data <= w_wr_data[0];
          end
          if (flush) begin
            r_busy <= 1'b0;
          end else if (w_alloc) begin
            r_busy <= 1'b1;
          end else if (|w_hit) begin
            r_busy <= 1'b0;
          end
        end
      end

      assign w_mem[r]  = r_data;
      assign w_busy[r] = r_busy;
    end
  end

  // Read ports: stored value/busy, then optional same-cycle data forwarding.
  // Busy is never forwarded.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_bsy;

    assign w_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Combinational read mux with load-port-priority bypass.
    always_comb begin
      w_data = '0;
      w_bsy  = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_addr == ADDR_WIDTH'(r)) begin
          w_data = w_mem[r];
          w_bsy  = w_busy[r];
        end
      end
      if (BYPASS) begin
        for (int k = 0; k < 2; k++) begin
          if (w_wr_ok[k] && (w_wr_addr[k] == w_addr)) begin
            w_data = w_wr_data[k];
          end
        end
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign rd_busy[i]                          = w_bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_register_file_mp                                        |
// | Description : Self-checking bench for register_file_mp. Three instances  |
// |               (bypass, no bypass, 24 regs / 4 read ports) share the      |
// |               write-side stimulus and are checked against an array model.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      we;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            flush;
  logic [4*AW-1:0] rd_addr;

  logic [2*DW-1:0] rd_data_a, rd_data_b;
  logic [1:0]      rd_busy_a, rd_busy_b;
  logic [4*DW-1:0] rd_data_c;
  logic [3:0]      rd_busy_c;

  register_file_mp #(.NUM_REGS(32), .NUM_READ(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr[2*AW-1:0]), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush));

  register_file_mp #(.NUM_REGS(32), .NUM_READ(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr[2*AW-1:0]), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush));

  register_file_mp #(.NUM_REGS(24), .NUM_READ(4), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_c),
    .rd_busy(rd_busy_c), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush));

  // Reference model: one architectural state per instance configuration.
  int          nregs [3] = '{32, 32, 24};
  bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
  int          nread [3] = '{2, 2, 4};
  logic [31:0] m_mem  [3][32];
  bit          m_busy [3][32];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit valid_addr(int c, int a);
    return (a != 0) && (a < nregs[c]);
  endfunction

  // Architectural read result given the current state and this cycle's writes.
  function automatic void exp_rd(input int c, input int a,
                                 output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (valid_addr(c, a)) begin
      d = m_mem[c][a];
      b = m_busy[c][a];
      if (byp[c]) begin
        if (we[0] && int'(wr_addr[AW-1:0]) == a)  d = wr_data[DW-1:0];
        if (we[1] && int'(wr_addr[2*AW-1:AW]) == a) d = wr_data[2*DW-1:DW];
      end
    end
  endfunction

  function automatic logic [31:0] obs_d(int c, int i);
    case (c)
      0:       return rd_data_a[i*DW +: DW];
      1:       return rd_data_b[i*DW +: DW];
      default: return rd_data_c[i*DW +: DW];
    endcase
  endfunction

  function automatic logic obs_b(int c, int i);
    case (c)
      0:       return rd_busy_a[i];
      1:       return rd_busy_b[i];
      default: return rd_busy_c[i];
    endcase
  endfunction

  // Apply one clock edge to the model: lowest priority first so later
  // rules override earlier ones.
  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      if (!rst) begin
        for (int r = 0; r < 32; r++) begin
          m_mem[c][r]  = '0;
          m_busy[c][r] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          int a;
          a = int'(wr_addr[k*AW +: AW]);
          if (we[k] && valid_addr(c, a)) begin
            m_mem[c][a]  = wr_data[k*DW +: DW];
            m_busy[c][a] = 1'b0;
          end
        end
        if (alloc_en && valid_addr(c, int'(alloc_addr))) m_busy[c][alloc_addr] = 1'b1;
        if (flush) for (int r = 0; r < 32; r++) m_busy[c][r] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < nread[c]; i++) begin
        logic [31:0] ed;
        logic        eb;
        exp_rd(c, int'(rd_addr[i*AW +: AW]), ed, eb);
        chk($sformatf("cfg%0d rd_data%0d addr %0d", c, i, rd_addr[i*AW +: AW]), obs_d(c, i), ed);
        chk($sformatf("cfg%0d rd_busy%0d addr %0d", c, i, rd_addr[i*AW +: AW]),
            {31'b0, obs_b(c, i)}, {31'b0, eb});
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; we = 2'b00; alloc_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wport(input int k, input int a, input logic [31:0] d);
    we[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = AW'(a);
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 11));
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    wr_addr = '0; wr_data = '0; alloc_addr = '0;
    set_rd(5, 5, 5, 5);
    tick();

    // Reset clears a previously written register.
    idle(); wport(0, 5, 32'hABCD_1234);
    settle(); tick();
    idle(); rst = 1'b0; wport(0, 6, 32'h1234_5678); alloc(5);
    settle(); tick();
    idle();
    settle();
    chk("reset r5 data", rd_data_a[31:0], 32'h0);
    chk("reset r5 busy", {31'b0, rd_busy_a[0]}, 32'h0);
    tick();

    // Write with and without bypass.
    idle(); wport(0, 5, 32'hABCD_1234); set_rd(5, 6, 5, 6);
    settle();
    chk("bypass r5", rd_data_a[31:0], 32'hABCD_1234);
    chk("nobypass r5 same cycle", rd_data_b[31:0], 32'h0);
    tick();
    idle();
    settle();
    chk("nobypass r5 next cycle", rd_data_b[31:0], 32'hABCD_1234);
    tick();

    // Register zero ignores writes and does not forward.
    idle(); wport(0, 0, 32'hFFFF_FFFF); set_rd(0, 5, 0, 0);
    settle();
    chk("x0 bypass", rd_data_a[31:0], 32'h0);
    tick();
    idle();
    settle();
    chk("x0 stored", rd_data_a[31:0], 32'h0);
    tick();

    // Dual write collision: load port wins.
    idle(); wport(0, 7, 32'h1111_1111); wport(1, 7, 32'h2222_2222); set_rd(7, 7, 7, 7);
    settle();
    chk("collision bypass", rd_data_a[31:0], 32'h2222_2222);
    tick();
    idle();
    settle();
    chk("collision stored", rd_data_b[31:0], 32'h2222_2222);
    tick();

    // Scoreboard: alloc, clearing write, alloc+write.
    idle(); alloc(9); set_rd(9, 9, 9, 9);
    settle(); tick();
    idle(); wport(1, 9, 32'h0000_00AA);
    settle();
    chk("busy r9 after alloc", {31'b0, rd_busy_a[0]}, 32'h1);
    chk("busy not bypassed data", rd_data_a[31:0], 32'h0000_00AA);
    tick();
    idle();
    settle();
    chk("busy r9 cleared", {31'b0, rd_busy_a[0]}, 32'h0);
    tick();
    idle(); alloc(9); wport(0, 9, 32'h0000_0055);
    settle(); tick();
    idle();
    settle();
    chk("alloc+write busy", {31'b0, rd_busy_a[0]}, 32'h1);
    chk("alloc+write data", rd_data_b[31:0], 32'h0000_0055);
    tick();

    // Flush overrides a same-cycle alloc.
    set_rd(3, 4, 6, 8);
    idle(); alloc(3); settle(); tick();
    idle(); alloc(4); settle(); tick();
    idle(); alloc(6); settle(); tick();
    idle(); alloc(8); flush = 1'b1; wport(0, 3, 32'h0BAD_F00D);
    settle();
    chk("pre-flush busy", {28'b0, rd_busy_c}, 32'h7);
    tick();
    idle(); set_rd(3, 4, 6, 9);
    settle();
    chk("flush busy", {28'b0, rd_busy_c}, 32'h0);
    chk("flush keeps data", rd_data_c[4*DW-1:3*DW], 32'h0000_0055);
    tick();

    // Out-of-range address on the 24-register instance.
    idle(); wport(0, 30, 32'hDEAD_BEEF); alloc(30); set_rd(30, 30, 30, 30);
    settle();
    chk("oor bypass", rd_data_c[31:0], 32'h0);
    tick();
    idle();
    settle();
    chk("oor data", rd_data_c[127:96], 32'h0);
    chk("oor busy", {28'b0, rd_busy_c}, 32'h0);
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 1) == 1) wport(0, rand_addr(), $urandom);
      if ($urandom_range(0, 2) == 0) wport(1, rand_addr(), $urandom);
      if ($urandom_range(0, 1) == 1) alloc(rand_addr());
      flush = ($urandom_range(0, 19) == 0);
      set_rd(rand_addr(), rand_addr(), rand_addr(), rand_addr());
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
